hazard_unit_scoreboard: RTL

//  Parametrised load-use / branch hazard unit for the 5-stage pipeline. Tracks in-flight loads in a
//  per-register countdown scoreboard, so a load whose data returns LOAD_LAT cycles after execute stalls

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_scoreboard.sv | 38 +++
 rtl/hazard_unit_scoreboard.sv | 99 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use / branch hazard unit.
package hazard_pkg;

  localparam int unsigned DEF_REG_AW   = 4;
  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam int unsigned MAX_SRC      = 8;

  typedef logic [DEF_REG_AW-1:0] reg_addr_t;

  // Countdown width able to hold LOAD_LAT-1.
  function automatic int unsigned sb_cw(input int unsigned load_lat);
    return int'($clog2(load_lat)) + 1;
  endfunction

  function automatic logic depends_on(input logic [MAX_SRC-1:0] rs_eq,
                                      input logic [MAX_SRC-1:0] rs_valid,
                                      input logic               rd_eq,
                                      input logic               rd_valid);
    return (|(rs_eq & rs_valid)) || (rd_eq && rd_valid);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown of in-flight loads; a nonzero count marks the register busy.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = DEF_REG_AW,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_issue,
  input  logic [REG_AW-1:0]     i_issue_rd,
  input  logic                  i_freeze,
  output logic [2**REG_AW-1:0]  o_busy
);

  localparam int unsigned NREG  = 2 ** REG_AW;
  localparam int unsigned SB_CW = sb_cw(LOAD_LAT);

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    logic [SB_CW-1:0] r_cnt;

    // A new issue to this register overrides its own decrement.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (!i_freeze) begin
        if (i_issue && (i_issue_rd == REG_AW'(r))) begin
          r_cnt <= SB_CW'(LOAD_LAT - 1);
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - SB_CW'(1);
        end
      end
    end

    assign o_busy[r] = (r_cnt != '0);
  end

endmodule

// File: rtl/hazard_unit_scoreboard.sv
// Load-use / branch hazard unit: operand matching, priority control mux, stall-cycle counter.
module hazard_unit_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = DEF_REG_AW,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_branch_taken,
  input  logic                      i_mem_busy,
  input  logic                      i_dec_mem_read,
  input  logic [REG_AW-1:0]         i_dec_rd,
  input  logic [NUM_SRC*REG_AW-1:0] i_fetch_rs,
  input  logic [NUM_SRC-1:0]        i_fetch_rs_valid,
  input  logic [REG_AW-1:0]         i_fetch_rd,
  input  logic                      i_fetch_rd_valid,
  output logic                      o_flush_fetch,
  output logic                      o_flush_decode,
  output logic                      o_stall_fetch,
  output logic                      o_pc_write,
  output logic [CNT_W-1:0]          o_stall_cycles
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [NREG-1:0]  w_busy;
  logic [NREG-1:0]  w_dep;
  logic             w_dec_hit;
  logic             w_hazard;
  logic             w_issue;
  logic [CNT_W-1:0] r_stall_cycles;

  // Per-register dependency of the fetch-stage instruction (sources and WAW destination).
  for (genvar r = 0; r < NREG; r++) begin : g_match
    logic [MAX_SRC-1:0] w_rs_eq;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_rs_eq[i] = (i_fetch_rs[i*REG_AW +: REG_AW] == REG_AW'(r));
    end
    if (NUM_SRC < MAX_SRC) begin : g_pad
      assign w_rs_eq[MAX_SRC-1:NUM_SRC] = '0;
    end
    assign w_dep[r] = depends_on(w_rs_eq, MAX_SRC'(i_fetch_rs_valid),
                                 i_fetch_rd == REG_AW'(r), i_fetch_rd_valid);
  end

  assign w_dec_hit = i_dec_mem_read && w_dep[i_dec_rd];
  assign w_hazard  = w_dec_hit || (|(w_busy & w_dep));

  // The load in decode still advances on a hazard bubble; only a taken branch squashes it.
  assign w_issue = i_dec_mem_read && !i_mem_busy && !i_branch_taken;

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (w_issue),
    .i_issue_rd (i_dec_rd),
    .i_freeze   (i_mem_busy),
    .o_busy     (w_busy)
  );

  always_comb begin
    o_flush_fetch  = 1'b0;
    o_flush_decode = 1'b0;
    o_stall_fetch  = 1'b0;
    o_pc_write     = 1'b1;
    if (!rst_n) begin
      o_flush_fetch  = 1'b1;
      o_flush_decode = 1'b1;
      o_pc_write     = 1'b0;
    end else if (i_mem_busy) begin
      o_stall_fetch  = 1'b1;
      o_pc_write     = 1'b0;
    end else if (i_branch_taken) begin
      o_flush_fetch  = 1'b1;
      o_flush_decode = 1'b1;
    end else if (w_hazard) begin
      o_stall_fetch  = 1'b1;
      o_flush_decode = 1'b1;
      o_pc_write     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (o_stall_fetch && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;

endmodule
